// File: rtl/alu_share_arbiter_if.sv
// Requester-side port bundle for alu_share_arbiter: one operation request channel
// and one response channel, both valid/ready.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output valid, a, b, op, rsp_ready,
        input  ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  valid, a, b, op, rsp_ready,
        output ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_OPCHECK_EN to flag opcodes 011/100/101 as illegal (ERR=1, RESULT=0).
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   req0,
    alu_share_arbiter_if.slave   req1,
    output logic [WIDTH-1:0]     alu_input_1,
    output logic [WIDTH-1:0]     alu_input_2,
    output logic [2:0]           alu_control,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b010;

    state_t                  state;
    logic                    last_owner;
    logic                    owner;
    logic                    err_pending;
    logic [1:0]              rsp_valid_q;
    logic [1:0]              rsp_zero_q;
    logic [1:0]              rsp_err_q;
    logic [1:0][WIDTH-1:0]   rsp_result_q;

    logic [1:0]              req_valid;
    logic [1:0]              rsp_ready;
    logic                    grant;
    logic                    accept;
    logic                    op_illegal;
    logic [WIDTH-1:0]        grant_a;
    logic [WIDTH-1:0]        grant_b;
    logic [2:0]              grant_op;

    assign req_valid = {req1.valid, req0.valid};
    assign rsp_ready = {req1.rsp_ready, req0.rsp_ready};

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11)
            grant = ~last_owner;
        else if (req_valid == 2'b10)
            grant = 1'b1;
    end

    // NOTE: READY is combinational, so it is gated by rst to show its reset value
    // while reset is held, not just after the flops clear.
    assign accept     = (state == IDLE) && (|req_valid) && !rst;
    assign req0.ready = accept && !grant;
    assign req1.ready = accept && grant;

    assign grant_a  = grant ? req1.a  : req0.a;
    assign grant_b  = grant ? req1.b  : req0.b;
    assign grant_op = grant ? req1.op : req0.op;

`ifdef ALU_ARB_OPCHECK_EN
    assign op_illegal = (grant_op == 3'b011) || (grant_op == 3'b100) || (grant_op == 3'b101);
`else
    assign op_illegal = 1'b0;
`endif

    // NOTE: all state below is sequential and uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_owner   <= 1'b1;
            owner        <= 1'b0;
            err_pending  <= 1'b0;
            alu_input_1  <= '0;
            alu_input_2  <= '0;
            alu_control  <= OP_ADD;
            rsp_valid_q  <= '0;
            rsp_zero_q   <= '0;
            rsp_err_q    <= '0;
            rsp_result_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_input_1 <= grant_a;
                        alu_input_2 <= grant_b;
                        alu_control <= op_illegal ? OP_ADD : grant_op;
                        err_pending <= op_illegal;
                        owner       <= grant;
                        last_owner  <= grant;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid_q[owner]  <= 1'b1;
                    rsp_result_q[owner] <= err_pending ? '0 : alu_result;
                    rsp_zero_q[owner]   <= err_pending ? 1'b0 : alu_zero;
                    rsp_err_q[owner]    <= err_pending;
                    state               <= RESP;
                end
                RESP: begin
                    // Clearing on handshake keeps idle response outputs at zero.
                    if (rsp_ready[owner]) begin
                        rsp_valid_q[owner]  <= 1'b0;
                        rsp_result_q[owner] <= '0;
                        rsp_zero_q[owner]   <= 1'b0;
                        rsp_err_q[owner]    <= 1'b0;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req0.rsp_valid  = rsp_valid_q[0];
    assign req0.rsp_result = rsp_result_q[0];
    assign req0.rsp_zero   = rsp_zero_q[0];
    assign req0.rsp_err    = rsp_err_q[0];
    assign req1.rsp_valid  = rsp_valid_q[1];
    assign req1.rsp_result = rsp_result_q[1];
    assign req1.rsp_zero   = rsp_zero_q[1];
    assign req1.rsp_err    = rsp_err_q[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural model of the shared ALU.
module tb_alu_share_arbiter;
    logic        clk;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctl;
    logic [31:0] alu_res;
    logic        alu_z;
    int          total;
    int          bad;

    alu_share_arbiter_if #(.WIDTH(32)) r0 ();
    alu_share_arbiter_if #(.WIDTH(32)) r1 ();

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (r0),
        .req1        (r1),
        .alu_input_1 (alu_a),
        .alu_input_2 (alu_b),
        .alu_control (alu_ctl),
        .alu_result  (alu_res),
        .alu_zero    (alu_z)
    );

    // External ALU; undefined control codes return a ^ b.
    always_comb begin
        case (alu_ctl)
            3'b010:  alu_res = alu_a + alu_b;
            3'b110:  alu_res = alu_a - alu_b;
            3'b000:  alu_res = alu_a & alu_b;
            3'b001:  alu_res = alu_a | alu_b;
            3'b111:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_res = alu_a ^ alu_b;
        endcase
    end
    assign alu_z = (alu_res == 32'd0);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  ctl;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic get_ready(input logic id);
        return id ? r1.ready : r0.ready;
    endfunction

    function automatic logic get_rsp_valid(input logic id);
        return id ? r1.rsp_valid : r0.rsp_valid;
    endfunction

    task automatic set_req(input logic id, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        if (id) begin
            r1.valid = v; r1.a = a; r1.b = b; r1.op = op;
        end else begin
            r0.valid = v; r0.a = a; r0.b = b; r0.op = op;
        end
    endtask

    // One full transaction with RSP_READY high; checks same-cycle READY,
    // operands on the ALU at t+1 and the response at t+2.
    task automatic do_txn(input string nm, input logic id, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op, input logic [2:0] ctl,
                          input logic [31:0] res, input logic zero, input logic err);
        int n;
        @(negedge clk);
        set_req(id, 1'b1, a, b, op);
        r0.rsp_ready = 1'b1;
        r1.rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!get_ready(id) && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({nm, "_ready"}, get_ready(id), 32'd1);
        check({nm, "_wait"}, n, 32'd0);
        @(negedge clk);
        set_req(id, 1'b0, 32'd0, 32'd0, 3'b010);
        #1;
        check({nm, "_alu_a"}, alu_a, a);
        check({nm, "_alu_b"}, alu_b, b);
        check({nm, "_alu_ctl"}, alu_ctl, ctl);
        check({nm, "_early_valid"}, get_rsp_valid(id), 32'd0);
        @(negedge clk);
        #1;
        check({nm, "_rsp_valid"}, get_rsp_valid(id), 32'd1);
        check({nm, "_other_valid"}, get_rsp_valid(!id), 32'd0);
        check({nm, "_result"}, id ? r1.rsp_result : r0.rsp_result, res);
        check({nm, "_zero"}, id ? r1.rsp_zero : r0.rsp_zero, zero);
        check({nm, "_err"}, id ? r1.rsp_err : r0.rsp_err, err);
    endtask

    initial begin
        int  n;
        logic exp_g;
        total = 0;
        bad   = 0;

        vecs[0] = '{1'b0, 32'd5, 32'd7, 3'b010, 3'b010, 32'd12, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'd9, 32'd9, 3'b110, 3'b110, 32'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 3'b000, 3'b000, 32'h0000_00F0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_F000, 32'h0000_000F, 3'b001, 3'b001, 32'h0000_F00F, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 3'b111, 3'b111, 32'd1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'd5, 32'd3, 3'b111, 3'b111, 32'd0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010, 3'b010, 32'd0, 1'b1, 1'b0};
`ifdef ALU_ARB_OPCHECK_EN
        vecs[7] = '{1'b1, 32'd3, 32'd1, 3'b101, 3'b010, 32'd0, 1'b0, 1'b1};
`else
        vecs[7] = '{1'b1, 32'd3, 32'd1, 3'b101, 3'b101, 32'd2, 1'b0, 1'b0};
`endif

        rst = 1'b1;
        set_req(1'b0, 1'b1, 32'd1, 32'd2, 3'b010);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b010);
        r0.rsp_ready = 1'b0;
        r1.rsp_ready = 1'b0;

        // Reset values, with a request already pending.
        @(negedge clk);
        #1;
        check("rst_ready0", r0.ready, 32'd0);
        check("rst_ready1", r1.ready, 32'd0);
        check("rst_rsp_valid", {r1.rsp_valid, r0.rsp_valid}, 32'd0);
        check("rst_rsp_result0", r0.rsp_result, 32'd0);
        check("rst_rsp_bits", {r1.rsp_zero, r1.rsp_err, r0.rsp_zero, r0.rsp_err}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctl", alu_ctl, 32'd2);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b010);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_txn($sformatf("v%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op,
                   vecs[i].ctl, vecs[i].res, vecs[i].zero, vecs[i].err);

        // Tie after reset, then continuous contention: grants 0,1,0,1.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(1'b0, 1'b1, 32'd1, 32'd1, 3'b010);
        set_req(1'b1, 1'b1, 32'd10, 32'd4, 3'b110);
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 1);
            #1;
            n = 0;
            while (!(r0.ready || r1.ready) && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            check($sformatf("tie%0d_grant", k), {r1.ready, r0.ready}, exp_g ? 32'd2 : 32'd1);
            @(negedge clk);
            @(negedge clk);
            #1;
            check($sformatf("tie%0d_rsp_valid", k), {r1.rsp_valid, r0.rsp_valid},
                  exp_g ? 32'd2 : 32'd1);
            check($sformatf("tie%0d_result", k), exp_g ? r1.rsp_result : r0.rsp_result,
                  exp_g ? 32'd6 : 32'd2);
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b010);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b010);

        // Back-pressure on requester 0 while requester 1 waits.
        @(negedge clk);
        r0.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 32'd20, 32'd22, 3'b010);
        set_req(1'b1, 1'b1, 32'd1, 32'd1, 3'b010);
        #1;
        check("bp_ready0", r0.ready, 32'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b010);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp%0d_valid", c), r0.rsp_valid, 32'd1);
            check($sformatf("bp%0d_result", c), r0.rsp_result, 32'd42);
            check($sformatf("bp%0d_ready", c), {r1.ready, r0.ready}, 32'd0);
        end
        r0.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_valid", r0.rsp_valid, 32'd0);
        check("bp_release_ready1", r1.ready, 32'd1);
        @(negedge clk);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b010);
        @(negedge clk);
        #1;
        check("bp_r1_valid", r1.rsp_valid, 32'd1);
        check("bp_r1_result", r1.rsp_result, 32'd2);

        // Reset during EXEC aborts the transaction.
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'd100, 32'd200, 3'b110);
        #1;
        check("re_ready0", r0.ready, 32'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b010);
        #1;
        check("re_exec_alu_a", alu_a, 32'd100);
        rst = 1'b1;
        #1;
        check("re_alu_a", alu_a, 32'd0);
        check("re_alu_b", alu_b, 32'd0);
        check("re_alu_ctl", alu_ctl, 32'd2);
        check("re_rsp_valid", {r1.rsp_valid, r0.rsp_valid}, 32'd0);
        check("re_rsp_result0", r0.rsp_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("re_quiet%0d", c), {r1.rsp_valid, r0.rsp_valid}, 32'd0);
        end
        do_txn("re_slt", 1'b1, 32'd2, 32'd3, 3'b111, 3'b111, 32'd1, 1'b0, 1'b0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Shares one combinational 32-bit ALU between two requesters (e.g. the main execute path and an address/branch-compare unit) using valid/ready handshakes and round-robin arbitration.
- Registers the granted operands, drives them onto the ALU for one cycle, captures the result and ZERO flag, and holds the response until the owning requester accepts it.
- Sits between the requesters and the ALU instance; the ALU is unchanged and is driven only by this block.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- REQn_VALID  input  1  (n = 0, 1) requester n presents an operation.
- REQn_READY  output  1  block accepts requester n's operation this cycle.
- REQn_A, REQn_B  input  WIDTH  operands, mapped to ALU INPUT_1 and INPUT_2.
- REQn_OP  input  3  ALU control code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- RSPn_VALID  output  1  response for requester n is available.
- RSPn_READY  input  1  requester n consumes the response.
- RSPn_RESULT  output  WIDTH  captured ALU result.
- RSPn_ZERO  output  1  captured ALU zero flag.
- RSPn_ERR  output  1  illegal opcode flag; tied 0 unless the configuration macro is defined.
- ALU_INPUT_1, ALU_INPUT_2  output  WIDTH  registered operands to the ALU.
- ALU_CONTROL  output  3  registered opcode to the ALU.
- ALU_RESULT  input  WIDTH  ALU output.
- ALU_ZERO  input  1  ALU zero flag.

## Operation
- FSM states and transitions:
  - IDLE → EXEC on an accepted request.
  - EXEC → RESP unconditionally.
  - RESP → IDLE when RSP<owner>_VALID & RSP<owner>_READY.
- Grant, combinational, in IDLE only:
  - With a single valid requester, that requester is granted.
  - With both valid, the requester not served last is granted.
  - REQn_READY = (state==IDLE) & grant==n; the other READY is 0.
  - A request is accepted when VALID & READY are both high.
- Arbitration pointer:
  - LAST_OWNER updates on each acceptance.
  - Reset value is 1, so requester 0 wins the first tie.
- On acceptance:
  - A, B and OP are registered into ALU_INPUT_1, ALU_INPUT_2 and ALU_CONTROL.
  - The owner id is stored.
- EXEC: at the end of the cycle, ALU_RESULT and ALU_ZERO are captured into the owner's response registers.
- RESP:
  - RSPn_VALID is high only for the owner.
  - RESULT, ZERO and ERR are held stable until the handshake completes.
  - Non-owner RSP outputs are 0.
- ALU_* outputs hold their last values outside EXEC.
- Requests are never dropped: a requester keeps VALID high until it sees READY; the other requester waits.
- RSPn_READY asserted while RSPn_VALID is low is ignored.

## Timing
- Reset values:
  - REQn_READY 0, RSPn_VALID 0, RSPn_RESULT 0, RSPn_ZERO 0, RSPn_ERR 0.
  - ALU_INPUT_1/2 0, ALU_CONTROL 3'b010.
  - State IDLE, LAST_OWNER 1.
- RESET asserted mid-operation (EXEC or RESP) aborts the transaction: no response is issued and the next op starts from IDLE.
- Latency:
  - Accept at cycle t puts operands on the ALU in cycle t+1.
  - RSP_VALID goes high in cycle t+2.
- Throughput: with RSP_READY held high, the next accept occurs at t+3, so one op per 3 cycles per block.
- Back-pressure: RSP_READY held low keeps the block in RESP indefinitely, with both REQ_READY at 0.
- Response sampling: RSP_* outputs are registered; RESULT is the ALU output sampled at the EXEC→RESP edge.

## Configuration
- ALU_ARB_OPCHECK_EN defined:
  - REQn_OP values 011, 100 and 101 are illegal.
  - An illegal request is still accepted and still passes through EXEC, but ALU_CONTROL is forced to 010.
  - The response carries RESULT=0, ZERO=0, ERR=1.
  - Latency is unchanged.
- ALU_ARB_OPCHECK_EN not defined: all opcodes are passed to the ALU unchanged and RSPn_ERR is constant 0.

## Test plan
- Single add: REQ0 A=5, B=7, OP=010 → REQ0_READY in the same cycle; RSP0_VALID 2 cycles later with RESULT=12, ZERO=0.
- Sub to zero: REQ1 A=9, B=9, OP=110 → RSP1_RESULT=0, RSP1_ZERO=1; RSP0_VALID stays 0.
- Tie then alternation: both VALID, then back-to-back ops → grants 0,1,0,1. A requester holding VALID waits at most one other transaction.
- Back-pressure: RSP0_READY held low for 5 cycles → RESULT stable, both REQ_READY 0; release → IDLE on the next cycle.
- Illegal opcode: OP=101, A=3, B=1
  - With ALU_ARB_OPCHECK_EN: ERR=1, RESULT=0.
  - Without it: ERR=0 and RESULT equals the ALU output for control 101.
- Reset in EXEC: assert RESET → all outputs reach their reset values immediately; no RSP_VALID afterwards. A fresh REQ1 slt (A=2, B=3) then returns RESULT=1.
